// File: rtl/cfg_sync_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cfg_sync_pkg
// Description : Shared FSM state type and counter-width helpers for the
//               configuration snapshot synchroniser.
// Revision    : 1.0
// ============================================================================
package cfg_sync_pkg;

    typedef enum logic [0:0] {
        DISABLED = 1'b0,
        ACTIVE   = 1'b1
    } cfg_state_e;

    // Width of a counter that must be able to hold max_val.
    function automatic int cnt_w(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

    localparam int STABLE_CNT_W_DEF  = cnt_w(2);
    localparam int TIMEOUT_CNT_W_DEF = cnt_w(1024);

endpackage
`default_nettype wire

// File: rtl/sync_stable_ch.sv
`default_nettype none
// ============================================================================
// Module      : sync_stable_ch
// Description : Multi-stage synchroniser for one config word plus a
//               saturating stability counter on the synchronised value.
// Revision    : 1.0
// ============================================================================
module sync_stable_ch
    import cfg_sync_pkg::*;
#(
    parameter int WIDTH        = 32,
    parameter int SYNC_DEPTH   = 3,
    parameter int STABLE_COUNT = 2
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] sync_q,
    output logic             ch_stable
);

    localparam int               CNT_W   = cnt_w(STABLE_COUNT);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_COUNT);

    logic [WIDTH-1:0] chain_q [SYNC_DEPTH];
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // A change is detected as it enters the last stage, so the counter is
    // already 0 in the first cycle the new synchronised value is visible.
    always_comb begin
        cnt_d = cnt_q;
        if (chain_q[SYNC_DEPTH-2] != chain_q[SYNC_DEPTH-1]) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < SYNC_DEPTH; i++) begin
                chain_q[i] <= '0;
            end
            cnt_q <= '0;
        end else begin
            chain_q[0] <= data_in;
            for (int i = 1; i < SYNC_DEPTH; i++) begin
                chain_q[i] <= chain_q[i-1];
            end
            cnt_q <= cnt_d;
        end
    end

    assign sync_q    = chain_q[SYNC_DEPTH-1];
    assign ch_stable = (cnt_q == CNT_MAX);

endmodule
`default_nettype wire

// File: rtl/cfg_snapshot_sync.sv
`default_nettype none
// ============================================================================
// Module      : cfg_snapshot_sync
// Description : Synchronises NUM_CH async config words and an enable, then
//               commits them atomically once all are stable and allowed.
// Revision    : 1.0
// ============================================================================
module cfg_snapshot_sync
    import cfg_sync_pkg::*;
#(
    parameter int NUM_CH         = 5,
    parameter int CH_WIDTH       = 32,
    parameter int SYNC_DEPTH     = 3,
    parameter int STABLE_COUNT   = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic [NUM_CH*CH_WIDTH-1:0] cfg_in,
    input  logic                       en_in,
    input  logic                       update_allow,
    output logic [NUM_CH*CH_WIDTH-1:0] cfg_out,
    output logic                       en_out,
    output logic                       cfg_update,
    output logic                       pending,
    output logic                       unstable_err
);

    localparam int               BUS_W   = NUM_CH * CH_WIDTH;
    localparam int               TMO_W   = cnt_w(TIMEOUT_CYCLES);
    localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT_CYCLES);

    logic [BUS_W-1:0]  snap_cfg;
    logic [NUM_CH-1:0] ch_stable;
    logic              en_sync;
    logic              en_stable;
    logic              all_stable;
    logic              diff;

    cfg_state_e        state_q;
    logic [BUS_W-1:0]  cfg_out_q;
    logic              en_out_q;
    logic              cfg_update_q;
    logic [TMO_W-1:0]  tmo_cnt_q;
    logic [TMO_W-1:0]  tmo_cnt_d;
    logic              unstable_err_q;

    generate
        for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
            sync_stable_ch #(
                .WIDTH        (CH_WIDTH),
                .SYNC_DEPTH   (SYNC_DEPTH),
                .STABLE_COUNT (STABLE_COUNT)
            ) u_sync (
                .clk       (clk),
                .resetn    (resetn),
                .data_in   (cfg_in[i*CH_WIDTH +: CH_WIDTH]),
                .sync_q    (snap_cfg[i*CH_WIDTH +: CH_WIDTH]),
                .ch_stable (ch_stable[i])
            );
        end
    endgenerate

    // The enable travels through the same qualification as the data words.
    sync_stable_ch #(
        .WIDTH        (1),
        .SYNC_DEPTH   (SYNC_DEPTH),
        .STABLE_COUNT (STABLE_COUNT)
    ) u_sync_en (
        .clk       (clk),
        .resetn    (resetn),
        .data_in   (en_in),
        .sync_q    (en_sync),
        .ch_stable (en_stable)
    );

    assign all_stable = (&ch_stable) & en_stable;
    assign diff       = (snap_cfg != cfg_out_q);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= DISABLED;
            cfg_out_q    <= '0;
            en_out_q     <= 1'b0;
            cfg_update_q <= 1'b0;
        end else begin
            cfg_update_q <= 1'b0;
            case (state_q)
                DISABLED: begin
                    if (all_stable && en_sync && update_allow) begin
                        cfg_out_q    <= snap_cfg;
                        en_out_q     <= 1'b1;
                        cfg_update_q <= 1'b1;
                        state_q      <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    // Disable wins over a simultaneous differing snapshot.
                    if (all_stable) begin
                        if (!en_sync) begin
                            en_out_q <= 1'b0;
                            state_q  <= DISABLED;
                        end else if (diff && update_allow) begin
                            cfg_out_q    <= snap_cfg;
                            cfg_update_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= DISABLED;
                end
            endcase
        end
    end

    always_comb begin
        tmo_cnt_d = tmo_cnt_q;
        if (all_stable) begin
            tmo_cnt_d = '0;
        end else if (tmo_cnt_q != TMO_MAX) begin
            tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tmo_cnt_q      <= '0;
            unstable_err_q <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            if (all_stable) begin
                unstable_err_q <= 1'b0;
            end else if (tmo_cnt_d == TMO_MAX) begin
                unstable_err_q <= 1'b1;
            end
        end
    end

    assign pending = all_stable && en_sync && !update_allow &&
                     ((state_q == DISABLED) || diff);

    assign cfg_out      = cfg_out_q;
    assign en_out       = en_out_q;
    assign cfg_update   = cfg_update_q;
    assign unstable_err = unstable_err_q;

endmodule
`default_nettype wire

// File: tb/tb_cfg_snapshot_sync.sv
`default_nettype none
// ============================================================================
// Module      : tb_cfg_snapshot_sync
// Description : Directed + random bench for cfg_snapshot_sync against a
//               history-based reference model.
// Revision    : 1.0
// ============================================================================
module tb_cfg_snapshot_sync;

    localparam int NUM_CH         = 5;
    localparam int CH_WIDTH       = 32;
    localparam int SYNC_DEPTH     = 3;
    localparam int STABLE_COUNT   = 2;
    localparam int TIMEOUT_CYCLES = 1024;
    localparam int BUS_W          = NUM_CH * CH_WIDTH;

    logic             clk = 1'b0;
    logic             resetn = 1'b0;
    logic [BUS_W-1:0] cfg_in = '0;
    logic             en_in = 1'b0;
    logic             update_allow = 1'b0;
    logic [BUS_W-1:0] cfg_out;
    logic             en_out;
    logic             cfg_update;
    logic             pending;
    logic             unstable_err;

    int checks = 0;
    int errors = 0;

    // Reference model state. hist[k] is {en, cfg} sampled at the k-th edge
    // after reset release; hist[0] stands for the all-zero reset contents.
    logic [BUS_W:0]   hist[$];
    int               n_edges;
    logic [BUS_W-1:0] m_cfg;
    logic             m_en;
    logic             m_upd;
    logic             m_err;
    int               m_tcnt;

    cfg_snapshot_sync #(
        .NUM_CH         (NUM_CH),
        .CH_WIDTH       (CH_WIDTH),
        .SYNC_DEPTH     (SYNC_DEPTH),
        .STABLE_COUNT   (STABLE_COUNT),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .cfg_in       (cfg_in),
        .en_in        (en_in),
        .update_allow (update_allow),
        .cfg_out      (cfg_out),
        .en_out       (en_out),
        .cfg_update   (cfg_update),
        .pending      (pending),
        .unstable_err (unstable_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [BUS_W-1:0] obs, input logic [BUS_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Synchronised value visible after edge n: the input sampled SYNC_DEPTH-1 edges earlier.
    function automatic logic [BUS_W:0] sync_at(input int n);
        int k;
        k = n - SYNC_DEPTH + 1;
        if (k < 1) return '0;
        return hist[k];
    endfunction

    // Everything is stable once the synchronised view has been unchanged for
    // STABLE_COUNT edges (and at least that many edges have passed since reset).
    function automatic logic model_all_stable(input int n);
        if (n < STABLE_COUNT) return 1'b0;
        for (int j = 1; j <= STABLE_COUNT; j++) begin
            if (sync_at(n - j) != sync_at(n)) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic logic model_pending();
        logic [BUS_W:0] sy;
        sy = sync_at(n_edges);
        return model_all_stable(n_edges) && sy[BUS_W] && !update_allow &&
               (!m_en || (sy[BUS_W-1:0] != m_cfg));
    endfunction

    task automatic model_clear();
        hist = {};
        hist.push_back('0);
        n_edges = 0;
        m_cfg   = '0;
        m_en    = 1'b0;
        m_upd   = 1'b0;
        m_err   = 1'b0;
        m_tcnt  = 0;
    endtask

    // One clock: compare at the falling edge, then advance the model on the rising edge.
    task automatic tick();
        logic [BUS_W:0] smp;
        logic [BUS_W:0] sy;
        logic           ua;
        logic           st;
        @(negedge clk);
        chk("cfg_out", cfg_out, m_cfg);
        chk("en_out", BUS_W'(en_out), BUS_W'(m_en));
        chk("cfg_update", BUS_W'(cfg_update), BUS_W'(m_upd));
        chk("pending", BUS_W'(pending), BUS_W'(model_pending()));
        chk("unstable_err", BUS_W'(unstable_err), BUS_W'(m_err));
        smp = {en_in, cfg_in};
        ua  = update_allow;
        st  = model_all_stable(n_edges);
        sy  = sync_at(n_edges);
        @(posedge clk);
        hist.push_back(smp);
        n_edges++;
        m_upd = 1'b0;
        if (st) begin
            if (!m_en) begin
                if (sy[BUS_W] && ua) begin
                    m_cfg = sy[BUS_W-1:0];
                    m_en  = 1'b1;
                    m_upd = 1'b1;
                end
            end else if (!sy[BUS_W]) begin
                m_en = 1'b0;
            end else if ((sy[BUS_W-1:0] != m_cfg) && ua) begin
                m_cfg = sy[BUS_W-1:0];
                m_upd = 1'b1;
            end
            m_tcnt = 0;
            m_err  = 1'b0;
        end else begin
            if (m_tcnt < TIMEOUT_CYCLES) m_tcnt++;
            if (m_tcnt == TIMEOUT_CYCLES) m_err = 1'b1;
        end
        #1;
    endtask

    // Asserts reset between edges, checks outputs clear at once, releases away from an edge.
    task automatic do_reset();
        resetn = 1'b0;
        #1;
        chk("rst_cfg_out", cfg_out, '0);
        chk("rst_en_out", BUS_W'(en_out), '0);
        chk("rst_cfg_update", BUS_W'(cfg_update), '0);
        chk("rst_pending", BUS_W'(pending), '0);
        chk("rst_unstable_err", BUS_W'(unstable_err), '0);
        cfg_in       = '0;
        en_in        = 1'b0;
        update_allow = 1'b0;
        @(posedge clk);
        #2;
        resetn = 1'b1;
        model_clear();
    endtask

    task automatic set_ch(input int c, input logic [CH_WIDTH-1:0] v);
        cfg_in[c*CH_WIDTH +: CH_WIDTH] = v;
    endtask

    task automatic enable_path();
        int first_upd;
        int n_upd;
        first_upd = -1;
        n_upd     = 0;
        for (int k = 0; k < 3; k++) tick();
        set_ch(0, 32'h0000_00FF);
        en_in        = 1'b1;
        update_allow = 1'b1;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (cfg_update) begin
                n_upd++;
                if (first_upd < 0) first_upd = k;
            end
        end
        chk("enable_latency", BUS_W'(first_upd), BUS_W'(SYNC_DEPTH + STABLE_COUNT));
        chk("enable_pulses", BUS_W'(n_upd), BUS_W'(1));
        chk("enable_ch0", BUS_W'(cfg_out[0 +: CH_WIDTH]), BUS_W'(32'h0000_00FF));
        chk("enable_en_out", BUS_W'(en_out), BUS_W'(1));
    endtask

    initial begin
        int n_upd;
        int err_edge;
        int mixed;
        logic [BUS_W-1:0] old_set;
        logic [BUS_W-1:0] new_set;

        model_clear();
        #3;
        do_reset();

        // Enable path from reset.
        enable_path();

        // Deferred update.
        update_allow = 1'b0;
        set_ch(2, 32'h0000_1234);
        for (int k = 0; k < 8; k++) tick();
        chk("defer_pending", BUS_W'(pending), BUS_W'(1));
        chk("defer_ch2_held", BUS_W'(cfg_out[2*CH_WIDTH +: CH_WIDTH]), '0);
        update_allow = 1'b1;
        tick();
        chk("defer_ch2_commit", BUS_W'(cfg_out[2*CH_WIDTH +: CH_WIDTH]), BUS_W'(32'h0000_1234));
        chk("defer_update", BUS_W'(cfg_update), BUS_W'(1));
        chk("defer_pending_clr", BUS_W'(pending), '0);
        tick();
        chk("defer_single_pulse", BUS_W'(cfg_update), '0);

        // Disable priority: ch1 change and enable drop arrive together.
        n_upd = 0;
        set_ch(1, 32'h0000_ABCD);
        en_in = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (cfg_update) n_upd++;
        end
        chk("dis_no_update", BUS_W'(n_upd), '0);
        chk("dis_en_out", BUS_W'(en_out), '0);
        chk("dis_ch1_held", BUS_W'(cfg_out[1*CH_WIDTH +: CH_WIDTH]), '0);
        update_allow = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        chk("dis_no_pending", BUS_W'(pending), '0);

        // Glitchy channel 3 while active.
        en_in        = 1'b1;
        update_allow = 1'b1;
        for (int k = 0; k < 10; k++) tick();
        err_edge = -1;
        n_upd    = 0;
        for (int k = 0; k < 1100; k++) begin
            set_ch(3, (k % 2 == 0) ? 32'h5A5A_5A5A : 32'hA5A5_A5A5);
            tick();
            if (unstable_err && err_edge < 0) err_edge = k;
            if (cfg_update) n_upd++;
        end
        chk("glitch_err_edge", BUS_W'(err_edge), BUS_W'(SYNC_DEPTH - 1 + TIMEOUT_CYCLES));
        chk("glitch_no_commit", BUS_W'(n_upd), '0);
        n_upd = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (cfg_update) n_upd++;
        end
        chk("glitch_err_clear", BUS_W'(unstable_err), '0);
        chk("glitch_settle_commit", BUS_W'(n_upd), BUS_W'(1));
        chk("glitch_ch3", BUS_W'(cfg_out[3*CH_WIDTH +: CH_WIDTH]), BUS_W'(32'hA5A5_A5A5));

        // Atomicity with staggered arrival.
        old_set = cfg_in;
        for (int c = 0; c < NUM_CH; c++) new_set[c*CH_WIDTH +: CH_WIDTH] = $urandom();
        mixed = 0;
        n_upd = 0;
        for (int k = 0; k < NUM_CH + 12; k++) begin
            if (k < NUM_CH) set_ch(k, new_set[k*CH_WIDTH +: CH_WIDTH]);
            tick();
            if (cfg_update) n_upd++;
            if (cfg_out !== old_set && cfg_out !== new_set) mixed++;
        end
        chk("atom_no_mixed", BUS_W'(mixed), '0);
        chk("atom_one_commit", BUS_W'(n_upd), BUS_W'(1));
        chk("atom_final", cfg_out, new_set);

        // Reset while pending and mid-settling.
        update_allow = 1'b0;
        set_ch(4, 32'hDEAD_BEEF);
        for (int k = 0; k < 8; k++) tick();
        chk("rst_pre_pending", BUS_W'(pending), BUS_W'(1));
        set_ch(0, 32'h0BAD_F00D);
        tick();
        #2;
        do_reset();
        enable_path();

        // Randomised traffic against the model.
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(5) == 0) set_ch($urandom_range(NUM_CH - 1), $urandom());
            if ($urandom_range(24) == 0) en_in = ~en_in;
            update_allow = ($urandom_range(9) < 7);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
